// File: rtl/instr_issue_unit.sv
// Instruction-issue front end: loader FIFO, instruction register and timestep counter for the decoder.
// Optional macro ISSUE_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module instr_issue_unit #(
    parameter int         DEPTH    = 8,
    parameter logic [9:0] NOP_WORD = 10'b0000000010
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [9:0]               wr_instr,
    output logic                     wr_ready,
    input  logic                     run,
    input  logic                     IRin,
    input  logic                     Clr,
    output logic [9:0]               IR,
    output logic [1:0]               timestep,
    output logic                     ir_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     hang
`ifdef ISSUE_RETIRE_CNT_EN
    ,
    output logic [15:0]              retire_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    function automatic logic [1:0] ts_sat_inc(input logic [1:0] ts);
        return (ts == 2'b11) ? 2'b11 : ts + 2'b01;
    endfunction

    // Full is judged on the registered count only, so a pop never frees a slot for a same-cycle push.
    assign wr_ready   = (count != FULL_CNT);
    assign push       = wr_valid && wr_ready;
    assign pop        = IRin && run && (count != '0);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            IR       <= NOP_WORD;
            ir_valid <= 1'b0;
            timestep <= 2'b00;
            hang     <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Issue reads the head as it stood before this edge: no write-to-issue bypass.
            if (IRin) begin
                if (pop) begin
                    IR       <= mem[rptr];
                    ir_valid <= 1'b1;
                end else begin
                    IR       <= NOP_WORD;
                    ir_valid <= 1'b0;
                end
            end
            if (Clr) begin
                timestep <= 2'b00;
            end else begin
                timestep <= ts_sat_inc(timestep);
                if (timestep == 2'b11) begin
                    hang <= 1'b1;
                end
            end
        end
    end

`ifdef ISSUE_RETIRE_CNT_EN
    // A real instruction completes when the decoder loads its successor while it is still valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt <= 16'h0000;
        end else if (IRin && Clr && ir_valid) begin
            retire_cnt <= retire_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: directed scenarios plus randomized traffic against a queue model.
// Honours ISSUE_RETIRE_CNT_EN when defined.
module tb_instr_issue_unit;

    localparam int         DEPTH = 8;
    localparam logic [9:0] NOP   = 10'b0000000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic [9:0] wr_instr = '0;
    logic       wr_ready;
    logic       run = 1'b0;
    logic       IRin = 1'b0;
    logic       Clr = 1'b0;
    logic [9:0] IR;
    logic [1:0] timestep;
    logic       ir_valid;
    logic [3:0] fifo_count;
    logic       hang;
`ifdef ISSUE_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [9:0] q[$];
    logic [9:0] m_ir = NOP;
    logic       m_iv = 1'b0;
    int         m_ts = 0;
    logic       m_hang = 1'b0;
    int         m_rc = 0;

    instr_issue_unit #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_instr(wr_instr),
        .wr_ready(wr_ready), .run(run), .IRin(IRin), .Clr(Clr), .IR(IR),
        .timestep(timestep), .ir_valid(ir_valid), .fifo_count(fifo_count),
        .hang(hang)
`ifdef ISSUE_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit do_push;
        bit do_pop;
        do_push = wr_valid && (q.size() != DEPTH);
        do_pop  = IRin && run && (q.size() > 0);
        if (!rst_n) begin
            q.delete();
            m_ir = NOP; m_iv = 1'b0; m_ts = 0; m_hang = 1'b0; m_rc = 0;
        end else begin
            if (IRin && Clr && m_iv) m_rc = (m_rc + 1) % 65536;
            if (IRin) begin
                if (do_pop) begin
                    m_ir = q.pop_front();
                    m_iv = 1'b1;
                end else begin
                    m_ir = NOP;
                    m_iv = 1'b0;
                end
            end
            if (Clr) m_ts = 0;
            else if (m_ts == 3) m_hang = 1'b1;
            else m_ts = m_ts + 1;
            if (do_push) q.push_back(wr_instr);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; wr_valid = 1'b0; run = 1'b0; IRin = 1'b0; Clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (IR !== NOP) begin bad++; $display("FAIL reset_IR got=%h want=%h", IR, NOP); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_ir_valid got=%b want=0", ir_valid); end
        total++; if (timestep !== 2'd0) begin bad++; $display("FAIL reset_timestep got=%0d want=0", timestep); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        total++; if (hang !== 1'b0) begin bad++; $display("FAIL reset_hang got=%b want=0", hang); end
        run = 1'b1; IRin = 1'b1; Clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (IR !== 10'h002 || ir_valid !== 1'b0 || timestep !== 2'd0)
                begin bad++; $display("FAIL nop_loop_ir got=%h/%b/%0d want=002/0/0", IR, ir_valid, timestep); end
            total++; if (fifo_count !== 4'd0 || wr_ready !== 1'b1)
                begin bad++; $display("FAIL nop_loop_fifo got=%0d/%b want=0/1", fifo_count, wr_ready); end
        end
    endtask

    task automatic test_single_issue();
        run = 1'b0; IRin = 1'b1; Clr = 1'b1;
        wr_valid = 1'b1; wr_instr = 10'b0100001000;
        tick();
        wr_valid = 1'b0;
        total++; if (IR !== NOP || ir_valid !== 1'b0)
            begin bad++; $display("FAIL halted_issue got=%h/%b want=%h/0", IR, ir_valid, NOP); end
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL halted_count got=%0d want=1", fifo_count); end
        run = 1'b1;
        tick();
        total++; if (IR !== 10'b0100001000 || ir_valid !== 1'b1)
            begin bad++; $display("FAIL run_issue got=%h/%b want=108/1", IR, ir_valid); end
        total++; if (timestep !== 2'd0 || fifo_count !== 4'd0)
            begin bad++; $display("FAIL run_issue_ts_count got=%0d/%0d want=0/0", timestep, fifo_count); end
    endtask

    task automatic test_hang();
        int exp_ts[4] = '{1, 2, 3, 3};
        logic exp_hang[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        IRin = 1'b0; Clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (timestep !== 2'(exp_ts[i]) || hang !== exp_hang[i])
                begin bad++; $display("FAIL hang_seq[%0d] got=ts%0d/h%b want=ts%0d/h%b", i, timestep, hang, exp_ts[i], exp_hang[i]); end
        end
        total++; if (IR !== 10'b0100001000 || ir_valid !== 1'b1)
            begin bad++; $display("FAIL hang_ir_hold got=%h/%b want=108/1", IR, ir_valid); end
        IRin = 1'b1; Clr = 1'b1;
        tick(); tick();
        total++; if (hang !== 1'b1 || timestep !== 2'd0)
            begin bad++; $display("FAIL hang_sticky got=h%b/ts%0d want=h1/ts0", hang, timestep); end
        do_reset();
        total++; if (hang !== 1'b0) begin bad++; $display("FAIL hang_cleared got=%b want=0", hang); end
    endtask

    task automatic test_full();
        logic [9:0] w[DEPTH];
        do_reset();
        run = 1'b1; Clr = 1'b1; IRin = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = 10'($urandom) | 10'h100;
            wr_valid = 1'b1; wr_instr = w[i];
            tick();
            total++; if (wr_ready !== (i < DEPTH - 1))
                begin bad++; $display("FAIL fill_wr_ready[%0d] got=%b want=%b", i, wr_ready, (i < DEPTH - 1)); end
        end
        wr_instr = 10'h3FF;
        tick();
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_drop_count got=%0d want=8", fifo_count); end
        IRin = 1'b1; wr_instr = 10'h2AA;
        tick();
        wr_valid = 1'b0;
        total++; if (fifo_count !== 4'd7 || IR !== w[0] || ir_valid !== 1'b1)
            begin bad++; $display("FAIL full_push_pop got=%0d/%h want=7/%h", fifo_count, IR, w[0]); end
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            total++; if (IR !== w[i] || fifo_count !== 4'(DEPTH - 1 - i))
                begin bad++; $display("FAIL drain[%0d] got=%h/%0d want=%h/%0d", i, IR, fifo_count, w[i], DEPTH - 1 - i); end
        end
        tick();
        total++; if (IR !== NOP || ir_valid !== 1'b0)
            begin bad++; $display("FAIL drain_empty got=%h/%b want=%h/0", IR, ir_valid, NOP); end
    endtask

    task automatic test_no_bypass();
        run = 1'b1; IRin = 1'b1; Clr = 1'b1;
        wr_valid = 1'b1; wr_instr = 10'h0C1;
        tick();
        wr_valid = 1'b0;
        total++; if (IR !== NOP || fifo_count !== 4'd1)
            begin bad++; $display("FAIL no_bypass got=%h/%0d want=%h/1", IR, fifo_count, NOP); end
        tick();
        total++; if (IR !== 10'h0C1 || ir_valid !== 1'b1 || fifo_count !== 4'd0)
            begin bad++; $display("FAIL bypass_next got=%h/%b/%0d want=0c1/1/0", IR, ir_valid, fifo_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        Clr = 1'b1; run = 1'b1; IRin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_instr = 10'(i + 9);
            tick();
        end
        wr_valid = 1'b0; IRin = 1'b1;
        tick();
        IRin = 1'b0; Clr = 1'b0;
        tick(); tick();
        total++; if (fifo_count !== 4'd5 || timestep !== 2'd2 || ir_valid !== 1'b1)
            begin bad++; $display("FAIL pre_reset got=%0d/%0d/%b want=5/2/1", fifo_count, timestep, ir_valid); end
        do_reset();
        total++; if (fifo_count !== 4'd0 || IR !== NOP || timestep !== 2'd0 || ir_valid !== 1'b0 || wr_ready !== 1'b1)
            begin bad++; $display("FAIL mid_reset got=%0d/%h/%0d/%b/%b want=0/%h/0/0/1", fifo_count, IR, timestep, ir_valid, wr_ready, NOP); end
    endtask

`ifdef ISSUE_RETIRE_CNT_EN
    task automatic test_retire();
        do_reset();
        run = 1'b1; Clr = 1'b1; IRin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_instr = 10'(i + 40);
            tick();
        end
        wr_valid = 1'b0; IRin = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        total++; if (retire_cnt !== 16'd3) begin bad++; $display("FAIL retire_cnt got=%0d want=3", retire_cnt); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            wr_valid = $urandom_range(0, 1) == 1;
            wr_instr = 10'($urandom);
            run      = $urandom_range(0, 3) != 0;
            IRin     = $urandom_range(0, 1) == 1;
            Clr      = $urandom_range(0, 2) != 0;
            tick();
            total++; if (IR !== m_ir || ir_valid !== m_iv)
                begin bad++; $display("FAIL rnd_ir[%0d] got=%h/%b want=%h/%b", n, IR, ir_valid, m_ir, m_iv); end
            total++; if (timestep !== 2'(m_ts) || hang !== m_hang)
                begin bad++; $display("FAIL rnd_ts[%0d] got=%0d/%b want=%0d/%b", n, timestep, hang, m_ts, m_hang); end
            total++; if (fifo_count !== 4'(q.size()) || wr_ready !== (q.size() != DEPTH))
                begin bad++; $display("FAIL rnd_fifo[%0d] got=%0d/%b want=%0d/%b", n, fifo_count, wr_ready, q.size(), (q.size() != DEPTH)); end
`ifdef ISSUE_RETIRE_CNT_EN
            total++; if (retire_cnt !== 16'(m_rc))
                begin bad++; $display("FAIL rnd_retire[%0d] got=%0d want=%0d", n, retire_cnt, m_rc); end
`endif
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_issue();
        test_hang();
        test_full();
        test_no_bypass();
        test_reset_mid();
`ifdef ISSUE_RETIRE_CNT_EN
        test_retire();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Instruction-issue front end for the 10-bit Blueberry-Pi core; it sits on the other side of the control decoder's IR/timestep/Clr/IRin interface.
- Buffers instruction words written by a loader (switches/UART/testbench) in a FIFO.
- Drives the instruction register and the timestep counter that the decoder consumes.
- Pops the next instruction when the decoder requests it; inserts NOP bubbles when there is no work or it is halted.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- NOP_WORD, 10'b0000000010, bubble word; IR[1:0]=2'b10 makes the decoder assert Clr+IRin every cycle

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- wr_valid  in  1  loader presents an instruction
- wr_instr  in  10  instruction word
- wr_ready  out  1  FIFO can accept a word (not full)
- run  in  1  1 = issue from FIFO; 0 = issue NOP only (halt/single-step hold)
- IRin  in  1  decoder request: load next instruction
- Clr  in  1  decoder request: clear timestep
- IR  out  10  instruction register
- timestep  out  2  step counter to decoder
- ir_valid  out  1  IR holds a real (popped) instruction, not a bubble
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- hang  out  1  sticky: timestep saturated without Clr

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - IR=NOP_WORD, ir_valid=0, timestep=0, hang=0.
  - FIFO emptied: fifo_count=0, wr_ready=1.
  - Reset mid-instruction discards the in-flight IR and all buffered words.
- Push: wr_valid && wr_ready at an edge writes wr_instr at the tail; count+1.
  - wr_ready = (count != DEPTH), combinational from registered count.
  - No write pass-through when full.
- Issue (IRin=1 at an edge):
  - If run=1 and count>0: IR ← head word, pop (count−1), ir_valid ← 1.
  - Else: IR ← NOP_WORD, ir_valid ← 0, no pop.
  - No bypass: a word pushed in the same cycle as an issue from an empty FIFO is not issued. It appears in the FIFO; IR gets NOP.
  - Simultaneous push+pop with 0<count<DEPTH: count unchanged, both pointers advance.
- IRin=0: IR and ir_valid hold.
- Timestep:
  - Clr=1 → timestep ← 0 next cycle.
  - Else timestep increments by 1, saturating at 2'b11.
  - If timestep==3 and Clr=0 at an edge → hang ← 1 (sticky until reset); timestep stays 3.
- Latency: IR and timestep update one cycle after IRin/Clr are sampled. Decoder sees the new instruction at timestep 0 on the following cycle.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; full/empty from the separate count register.
- Storage: FIFO array has no reset requirement; only pointers/count reset.
- Timing: all outputs are registered except wr_ready.

Optional Feature:
- Macro ISSUE_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt (16-bit).
  - Reset 0; increments at each edge where IRin=1 && Clr=1 && ir_valid=1, i.e. a real instruction completes.
  - Wraps 16'hFFFF→0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle, run=1, IRin=1 and Clr=1 each cycle (decoder NOP loop) → IR=10'h002, ir_valid=0, timestep=0, fifo_count=0, wr_ready=1.
- Push 10'b0100001000 (add R1,R0) with run=0, then IRin=1 → IR stays NOP, fifo_count=1. Set run=1, IRin=1 → next cycle IR=10'b0100001000, ir_valid=1, timestep=0, fifo_count=0.
- Hold Clr=0 for 4 cycles after issue → timestep 0,1,2,3,3; hang=1 on the cycle after timestep reaches 3 with Clr=0; hang stays 1 until rst_n=0.
- Push DEPTH=8 words with IRin=0 → wr_ready=0 after the 8th; a 9th push is dropped (count stays 8).
  - Then push+pop in the same cycle while full → pop occurs, push rejected, count=7.
  - Drain in order → words issued in FIFO order.
- FIFO empty, push 10'h0C1 and IRin=1 in the same cycle → IR=NOP, count=1. Next IRin issues 10'h0C1.
- Assert rst_n=0 for one edge with count=5, timestep=2 → count=0, IR=NOP, timestep=0, ir_valid=0. With ISSUE_RETIRE_CNT_EN: 3 completed real instructions → retire_cnt=3; bubbles do not count.
